// File: rtl/hex_scan_display_pkg.sv
// hex_disp_pkg: glyph constants and width helpers for the hex scanner.
// Glyphs are stored active-low ({a,b,c,d,e,f,g}, 0 = lit).
`timescale 1ns/1ps
package hex_disp_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [6:0] GLYPH_0 = 7'b0000001;
    localparam logic [6:0] GLYPH_1 = 7'b1001111;
    localparam logic [6:0] GLYPH_2 = 7'b0010010;
    localparam logic [6:0] GLYPH_3 = 7'b0000110;
    localparam logic [6:0] GLYPH_4 = 7'b1001100;
    localparam logic [6:0] GLYPH_5 = 7'b0100100;
    localparam logic [6:0] GLYPH_6 = 7'b0100000;
    localparam logic [6:0] GLYPH_7 = 7'b0001111;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0000100;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b1100000;
    localparam logic [6:0] GLYPH_C = 7'b0110001;
    localparam logic [6:0] GLYPH_D = 7'b1000010;
    localparam logic [6:0] GLYPH_E = 7'b0110000;
    localparam logic [6:0] GLYPH_F = 7'b0111000;

    // Counter width able to hold 0..n-1, never narrower than 1 bit.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int idx_width(input int num_digits);
        return width_of(num_digits);
    endfunction

    function automatic int presc_width(input int refresh_div);
        return width_of(refresh_div);
    endfunction

endpackage

// File: rtl/hex_scan_display_if.sv
// hex_scan_display_if: host-side data/blank inputs and pin-side scan outputs.
// master = host/bench, slave = display driver.
`timescale 1ns/1ps
interface hex_scan_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] data_in;
    logic                    data_valid;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic [6:0]              seg_out;
    logic [NUM_DIGITS-1:0]   dig_en;
    logic                    frame_done;

    modport master (
        output data_in,
        output data_valid,
        output blank_in,
        input  seg_out,
        input  dig_en,
        input  frame_done
    );

    modport slave (
        input  data_in,
        input  data_valid,
        input  blank_in,
        output seg_out,
        output dig_en,
        output frame_done
    );
endinterface

// File: rtl/hex_scan_display_hex_to_seg.sv
// hex_to_seg: 4-bit nibble to active-low 7-segment glyph, combinational.
// Ports: i_nib (nibble), o_seg ({a..g}, 0 = lit).
`timescale 1ns/1ps
module hex_to_seg
    import hex_disp_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        unique case (i_nib)
            4'h0: o_seg = GLYPH_0;
            4'h1: o_seg = GLYPH_1;
            4'h2: o_seg = GLYPH_2;
            4'h3: o_seg = GLYPH_3;
            4'h4: o_seg = GLYPH_4;
            4'h5: o_seg = GLYPH_5;
            4'h6: o_seg = GLYPH_6;
            4'h7: o_seg = GLYPH_7;
            4'h8: o_seg = GLYPH_8;
            4'h9: o_seg = GLYPH_9;
            4'hA: o_seg = GLYPH_A;
            4'hB: o_seg = GLYPH_B;
            4'hC: o_seg = GLYPH_C;
            4'hD: o_seg = GLYPH_D;
            4'hE: o_seg = GLYPH_E;
            4'hF: o_seg = GLYPH_F;
        endcase
    end

endmodule

// File: rtl/hex_scan_display.sv
// hex_scan_display: time-multiplexed hex driver with prescaler, shadow
// register (frame-synchronous update) and per-digit blanking.
// Ports: clk, rst_n (async active-low), bus (slave): data_in, data_valid,
// blank_in in; seg_out, dig_en, frame_done out (all registered).
// Optional macro LEADING_ZERO_BLANK_EN: also darken leading zero digits.
`timescale 1ns/1ps
module hex_scan_display
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic clk,
    input  logic rst_n,
    hex_scan_display_if.slave bus
);

    localparam int IW = idx_width(NUM_DIGITS);
    localparam int PW = presc_width(REFRESH_DIV);
    localparam int DW = 4 * NUM_DIGITS;

    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    localparam logic SEG_INV = (SEG_ACTIVE_LOW == 0);
    localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);

    localparam logic [6:0] SEG_DARK = SEG_OFF ^ {7{SEG_INV}};
    localparam logic [NUM_DIGITS-1:0] DIG_IDLE = {NUM_DIGITS{DIG_INV}};

    logic [PW-1:0]         r_presc;
    logic [IW-1:0]         r_idx;
    logic [DW-1:0]         r_disp;
    logic [DW-1:0]         r_pend;
    logic                  r_pend_valid;
    logic                  r_frame_done;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_dig;

    logic                       w_tick;
    logic                       w_boundary;
    logic [NUM_DIGITS-1:0][3:0] w_nibs;
    logic [3:0]                 w_nib;
    logic [6:0]                 w_glyph;
    logic [NUM_DIGITS-1:0]      w_lz;
    logic                       w_blank;
    logic [NUM_DIGITS-1:0]      w_onehot;

    assign w_tick     = (r_presc == PRESC_LAST);
    assign w_boundary = w_tick && (r_idx == IDX_LAST);

    assign w_nibs   = r_disp;
    assign w_nib    = w_nibs[r_idx];
    assign w_onehot = NUM_DIGITS'(1) << r_idx;

    hex_to_seg u_hex_to_seg (
        .i_nib (w_nib),
        .o_seg (w_glyph)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; a digit is dark while every nibble
    // at or above it is zero. Digit 0 is never darkened.
    logic w_zero_above;

    always_comb begin
        w_lz         = '0;
        w_zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_zero_above = w_zero_above & (w_nibs[k] == 4'h0);
            w_lz[k]      = w_zero_above;
        end
    end
`else
    assign w_lz = '0;
`endif

    assign w_blank = bus.blank_in[r_idx] | w_lz[r_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_tick) begin
            if (r_idx == IDX_LAST) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Shadow capture: strobes land in r_pend mid-frame; r_disp is only
    // written on the frame boundary so a scan never mixes two values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp       <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
        end else if (w_boundary) begin
            if (bus.data_valid) begin
                r_disp <= bus.data_in;
            end else if (r_pend_valid) begin
                r_disp <= r_pend;
            end
            r_pend_valid <= 1'b0;
        end else if (bus.data_valid) begin
            r_pend       <= bus.data_in;
            r_pend_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_done <= 1'b0;
            r_seg        <= SEG_DARK;
            r_dig        <= DIG_IDLE;
        end else begin
            r_frame_done <= w_boundary;
            r_seg        <= w_blank ? SEG_DARK : (w_glyph ^ {7{SEG_INV}});
            r_dig        <= w_blank ? DIG_IDLE
                                    : (w_onehot ^ {NUM_DIGITS{DIG_INV}});
        end
    end

    assign bus.seg_out    = r_seg;
    assign bus.dig_en     = r_dig;
    assign bus.frame_done = r_frame_done;

endmodule
